// File: rtl/stdp_pkg.sv
// +----------------------------------------------------------------------------+
// | stdp_pkg                                                                   |
// | Shared state encoding, default time constants and width helper for the     |
// | STDP pair scheduler.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package stdp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [31:0] C_TICK_INC = 32'h0001_0000;
    localparam logic [31:0] C_WINDOW_T = 32'h0028_0000;

    // One extra bit so the difference of two unsigned stamps keeps its sign.
    function automatic int diff_width(input int w);
        return w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stdp_time_base.sv
// +----------------------------------------------------------------------------+
// | stdp_time_base                                                             |
// | Free-running Q16.16 time base; wraps back to TICK_INC so it is never 0.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stdp_time_base
    import stdp_pkg::*;
#(
    parameter int                     BUFFER_TIME = 32,
    parameter logic [BUFFER_TIME-1:0] TICK_INC    = BUFFER_TIME'(C_TICK_INC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_en,
    output logic [BUFFER_TIME-1:0] now_t,
    output logic                   wrap_pulse
);

    logic [BUFFER_TIME-1:0] r_now;
    logic [BUFFER_TIME:0]   w_sum;

    assign w_sum      = {1'b0, r_now} + {1'b0, TICK_INC};
    assign wrap_pulse = tick_en && (w_sum[BUFFER_TIME] || (w_sum[BUFFER_TIME-1:0] == '0));
    assign now_t      = r_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_now <= TICK_INC;
        end else if (wrap_pulse) begin
            r_now <= TICK_INC;
        end else if (tick_en) begin
            r_now <= w_sum[BUFFER_TIME-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/stdp_pair_scheduler.sv
// +----------------------------------------------------------------------------+
// | stdp_pair_scheduler                                                        |
// | Pairs pre/post spikes inside the STDP window, drives the weight-update     |
// | datapath and writes back its result. Define STDP_DROP_CNT_EN to add the    |
// | drop_cnt output counting spikes lost on a full pending slot.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stdp_pair_scheduler
    import stdp_pkg::*;
#(
    parameter int                     BUFFER_TIME = 32,
    parameter int                     BUFFER_SIZE = 32,
    parameter logic [BUFFER_TIME-1:0] TICK_INC    = BUFFER_TIME'(C_TICK_INC),
    parameter logic [BUFFER_TIME-1:0] WINDOW_T    = BUFFER_TIME'(C_WINDOW_T),
    parameter logic [BUFFER_SIZE-1:0] W_INIT      = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_en,
    input  logic                   pre_spike,
    input  logic                   post_spike,
    input  logic                   w_load,
    input  logic [BUFFER_SIZE-1:0] w_load_data,
    output logic [BUFFER_TIME-1:0] t_pre,
    output logic [BUFFER_TIME-1:0] t_post,
    output logic [BUFFER_SIZE-1:0] w_previous,
    input  logic [BUFFER_SIZE-1:0] w_new,
    output logic [BUFFER_SIZE-1:0] weight,
    output logic                   busy,
`ifdef STDP_DROP_CNT_EN
    output logic [15:0]            drop_cnt,
`endif
    output logic                   update_done
);

    localparam int DW = diff_width(BUFFER_TIME);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BUFFER_TIME-1:0] w_now;
    logic                   w_wrap;
    logic                   r_pre_v;
    logic                   r_post_v;
    logic [BUFFER_TIME-1:0] r_pre_t;
    logic [BUFFER_TIME-1:0] r_post_t;
    logic [BUFFER_TIME-1:0] r_last_pre;
    logic [BUFFER_TIME-1:0] r_last_post;
    logic [BUFFER_TIME-1:0] r_t_pre;
    logic [BUFFER_TIME-1:0] r_t_post;
    logic [BUFFER_SIZE-1:0] r_weight;
    logic                   r_done;
    logic                   w_issue;
    logic                   w_use_pre;
    logic                   w_use_post;
    logic [BUFFER_TIME-1:0] w_iss_pre;
    logic [BUFFER_TIME-1:0] w_iss_post;

    function automatic logic in_window(input logic [BUFFER_TIME-1:0] a,
                                       input logic [BUFFER_TIME-1:0] b);
        logic signed [DW-1:0] d;
        logic        [DW-1:0] mag;
        d   = $signed({1'b0, a}) - $signed({1'b0, b});
        mag = d[DW-1] ? $unsigned(-d) : $unsigned(d);
        return mag < {1'b0, WINDOW_T};
    endfunction

    stdp_time_base #(
        .BUFFER_TIME (BUFFER_TIME),
        .TICK_INC    (TICK_INC)
    ) u_time_base (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .now_t      (w_now),
        .wrap_pulse (w_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A host write or a time-base wrap preempts pair evaluation for that cycle.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_use_pre    = 1'b0;
        w_use_post   = 1'b0;
        w_iss_pre    = '0;
        w_iss_post   = '0;
        case (r_state)
            IDLE: begin
                if (!w_load && !w_wrap) begin
                    if (r_pre_v && r_post_v) begin
                        w_use_pre  = 1'b1;
                        w_use_post = 1'b1;
                        w_iss_pre  = r_pre_t;
                        w_iss_post = r_post_t;
                        w_issue    = in_window(r_pre_t, r_post_t);
                    end else if (r_post_v) begin
                        w_use_post = 1'b1;
                        w_iss_pre  = r_last_pre;
                        w_iss_post = r_post_t;
                        w_issue    = (r_last_pre != '0) && in_window(r_post_t, r_last_pre);
                    end else if (r_pre_v) begin
                        w_use_pre  = 1'b1;
                        w_iss_pre  = r_pre_t;
                        w_iss_post = r_last_post;
                        w_issue    = (r_last_post != '0) && in_window(r_pre_t, r_last_post);
                    end
                end
                if (w_issue) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE:   w_state_next = CAPTURE;
            CAPTURE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t_pre  <= '0;
            r_t_post <= '0;
            r_weight <= W_INIT;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == CAPTURE);
            if (r_state == CAPTURE) begin
                r_weight <= w_new;
                r_t_pre  <= '0;
                r_t_post <= '0;
            end else if (w_issue) begin
                r_t_pre  <= w_iss_pre;
                r_t_post <= w_iss_post;
            end else if ((r_state == IDLE) && w_load) begin
                r_weight <= w_load_data;
            end
        end
    end

    // A spike finding its slot already occupied is lost, even if that slot
    // is being consumed in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_v     <= 1'b0;
            r_post_v    <= 1'b0;
            r_pre_t     <= '0;
            r_post_t    <= '0;
            r_last_pre  <= '0;
            r_last_post <= '0;
        end else if (w_wrap) begin
            r_pre_v     <= 1'b0;
            r_post_v    <= 1'b0;
            r_pre_t     <= '0;
            r_post_t    <= '0;
            r_last_pre  <= '0;
            r_last_post <= '0;
        end else begin
            if (w_use_pre) begin
                r_last_pre <= r_pre_t;
            end
            if (w_use_post) begin
                r_last_post <= r_post_t;
            end
            if (pre_spike && !r_pre_v) begin
                r_pre_v <= 1'b1;
                r_pre_t <= w_now;
            end else if (w_use_pre) begin
                r_pre_v <= 1'b0;
            end
            if (post_spike && !r_post_v) begin
                r_post_v <= 1'b1;
                r_post_t <= w_now;
            end else if (w_use_post) begin
                r_post_v <= 1'b0;
            end
        end
    end

`ifdef STDP_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic [1:0]  w_drops;
    logic [16:0] w_drop_sum;

    assign w_drops    = {1'b0, pre_spike & r_pre_v & ~w_wrap}
                      + {1'b0, post_spike & r_post_v & ~w_wrap};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'b0, w_drops};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign t_pre       = r_t_pre;
    assign t_post      = r_t_post;
    assign w_previous  = r_weight;
    assign weight      = r_weight;
    assign busy        = (r_state != IDLE);
    assign update_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_stdp_pair_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_stdp_pair_scheduler                                                     |
// | Self-checking bench: directed scenarios plus random spikes vs. a model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stdp_pair_scheduler;

    localparam logic [31:0] TICK  = 32'h0001_0000;
    localparam logic [31:0] WIN   = 32'h0028_0000;
    localparam logic [31:0] WINIT = 32'h0000_1234;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick_en = 1'b0;
    logic        pre_spike = 1'b0;
    logic        post_spike = 1'b0;
    logic        w_load = 1'b0;
    logic [31:0] w_load_data = '0;
    logic [31:0] t_pre, t_post, w_previous, w_new, weight;
    logic        busy, update_done;
`ifdef STDP_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int n_iss = 0;
    bit prev_busy = 1'b0;

    // Model state: time, pending slots, last stamps, issued pair and its age.
    longint unsigned m_now;
    bit          m_pre_v, m_post_v, m_done;
    logic [31:0] m_pre_t, m_post_t, m_last_pre, m_last_post, m_ip, m_iq, m_w;
    int          m_age, m_drop;

    always #5 clk = ~clk;

    // Datapath stub: only produces a sensible weight while a pair is presented.
    assign w_new = (t_pre != 32'h0 || t_post != 32'h0) ? w_previous + 32'd1 : 32'hDEAD_BEEF;

    stdp_pair_scheduler #(
        .BUFFER_TIME (32),
        .BUFFER_SIZE (32),
        .TICK_INC    (TICK),
        .WINDOW_T    (WIN),
        .W_INIT      (WINIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_en     (tick_en),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .w_load      (w_load),
        .w_load_data (w_load_data),
        .t_pre       (t_pre),
        .t_post      (t_post),
        .w_previous  (w_previous),
        .w_new       (w_new),
        .weight      (weight),
        .busy        (busy),
`ifdef STDP_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .update_done (update_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_now = 64'(TICK);
        m_pre_v = 0; m_post_v = 0; m_done = 0;
        m_pre_t = '0; m_post_t = '0; m_last_pre = '0; m_last_post = '0;
        m_ip = '0; m_iq = '0; m_w = WINIT; m_age = 0; m_drop = 0;
    endtask

    task automatic model_issue(input logic [31:0] tp, input logic [31:0] tq);
        m_ip = tp; m_iq = tq; m_age = 1;
    endtask

    task automatic model_eval();
        longint d;
        if (m_pre_v && m_post_v) begin
            d = longint'(m_post_t) - longint'(m_pre_t);
            if (d < 0) d = -d;
            if (d < longint'(WIN)) model_issue(m_pre_t, m_post_t);
            m_last_pre = m_pre_t; m_last_post = m_post_t;
            m_pre_v = 0; m_post_v = 0;
        end else if (m_post_v) begin
            d = longint'(m_post_t) - longint'(m_last_pre);
            if (m_last_pre != 0 && d < longint'(WIN)) model_issue(m_last_pre, m_post_t);
            m_last_post = m_post_t; m_post_v = 0;
        end else if (m_pre_v) begin
            d = longint'(m_pre_t) - longint'(m_last_post);
            if (m_last_post != 0 && d < longint'(WIN)) model_issue(m_pre_t, m_last_post);
            m_last_pre = m_pre_t; m_pre_v = 0;
        end
    endtask

    task automatic model_step(input bit p, input bit q, input bit t, input bit wl,
                              input logic [31:0] wd);
        bit wrap, old_pre_v, old_post_v;
        wrap = t && ((m_now + 64'(TICK)) >= 64'h1_0000_0000);
        old_pre_v = m_pre_v;
        old_post_v = m_post_v;
        m_done = 0;
        if (m_age == 2) begin
            m_w = m_w + 32'd1; m_age = 0; m_done = 1;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (wl) begin
            m_w = wd;
        end else if (!wrap) begin
            model_eval();
        end
        if (wrap) begin
            m_pre_v = 0; m_post_v = 0; m_pre_t = '0; m_post_t = '0;
            m_last_pre = '0; m_last_post = '0;
            m_now = 64'(TICK);
        end else begin
            if (p) begin
                if (old_pre_v) m_drop++;
                else begin m_pre_v = 1; m_pre_t = m_now[31:0]; end
            end
            if (q) begin
                if (old_post_v) m_drop++;
                else begin m_post_v = 1; m_post_t = m_now[31:0]; end
            end
            if (t) m_now = m_now + 64'(TICK);
        end
    endtask

    task automatic compare_all();
        chk("t_pre", t_pre, (m_age != 0) ? m_ip : 32'h0);
        chk("t_post", t_post, (m_age != 0) ? m_iq : 32'h0);
        chk("weight", weight, m_w);
        chk("w_previous", w_previous, m_w);
        chk("busy", 32'(busy), 32'(m_age != 0));
        chk("update_done", 32'(update_done), 32'(m_done));
`ifdef STDP_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), (m_drop > 65535) ? 32'hFFFF : 32'(m_drop));
`endif
    endtask

    task automatic cyc(input bit p, input bit q, input bit t, input bit wl, input logic [31:0] wd);
        pre_spike = p; post_spike = q; tick_en = t; w_load = wl; w_load_data = wd;
        @(posedge clk);
        model_step(p, q, t, wl, wd);
        @(negedge clk);
        compare_all();
        if (busy && !prev_busy) n_iss++;
        prev_busy = busy;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, '0);
    endtask

    task automatic nt(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pre_spike = 0; post_spike = 0; tick_en = 0; w_load = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        prev_busy = 1'b0;
        n_iss = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_weight", weight, 32'h0000_1234);
        chk("rst_t_pre", t_pre, 32'h0);
        chk("rst_t_post", t_post, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_update_done", 32'(update_done), 32'h0);

        // Simultaneous pre/post at now=1.0, then a pre captured and a pre dropped
        cyc(1, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("same_t_pre", t_pre, 32'h0001_0000);
        chk("same_t_post", t_post, 32'h0001_0000);
        chk("same_busy", 32'(busy), 32'h1);
        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        chk("same_weight", weight, 32'h0000_1235);
        chk("same_done", 32'(update_done), 32'h1);
`ifdef STDP_DROP_CNT_EN
        chk("drop_one", 32'(drop_cnt), 32'h1);
`endif
        nt(4);

        // Pre 3.0 then post 8.0: potentiation pair
        do_reset();
        tk(2);
        cyc(1, 0, 1, 0, '0);
        tk(4);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("pot_t_pre", t_pre, 32'h0003_0000);
        chk("pot_t_post", t_post, 32'h0008_0000);
        cyc(0, 0, 0, 0, '0);
        chk("pot_weight_hold", weight, 32'h0000_1234);
        cyc(0, 0, 0, 0, '0);
        chk("pot_weight", weight, 32'h0000_1235);
        chk("pot_done", 32'(update_done), 32'h1);
        cyc(0, 0, 0, 0, '0);
        chk("pot_done_pulse", 32'(update_done), 32'h0);
        nt(3);
        chk("pot_issue_count", 32'(n_iss), 32'h1);

        // Post 5.0 then pre 7.0: depression pair
        do_reset();
        tk(4);
        cyc(0, 1, 1, 0, '0);
        tk(1);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("dep_t_pre", t_pre, 32'h0007_0000);
        chk("dep_t_post", t_post, 32'h0005_0000);
        nt(4);

        // Delta exactly 40.0 is outside the window
        do_reset();
        tk(1);
        cyc(1, 0, 1, 0, '0);
        tk(39);
        cyc(0, 1, 0, 0, '0);
        nt(4);
        chk("win_edge_issues", 32'(n_iss), 32'h0);
        chk("win_edge_weight", weight, 32'h0000_1234);

        // Delta 39.0 is inside
        do_reset();
        tk(1);
        cyc(1, 0, 1, 0, '0);
        tk(38);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("win_in_t_pre", t_pre, 32'h0002_0000);
        chk("win_in_t_post", t_post, 32'h0029_0000);
        nt(3);
        chk("win_in_weight", weight, 32'h0000_1235);

        // Time-base wrap clears the last stamps and restarts at 1.0
        do_reset();
        cyc(1, 0, 1, 0, '0);
        tk(65533);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 1, 0, 0, '0);
        nt(3);
        chk("wrap_no_issue", 32'(n_iss), 32'h0);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("wrap_t_pre", t_pre, 32'h0001_0000);
        chk("wrap_t_post", t_post, 32'h0001_0000);
        nt(3);

        // Reset during CAPTURE aborts the update
        do_reset();
        cyc(1, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        reset = 1'b0;
        #1;
        chk("abort_weight", weight, 32'h0000_1234);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_t_pre", t_pre, 32'h0);
        chk("abort_done", 32'(update_done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        prev_busy = 1'b0;
        nt(3);
        chk("abort_weight_after", weight, 32'h0000_1234);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                ($urandom % 40) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stdp_pair_scheduler.md
Name: stdp_pair_scheduler

Overview:
- Front end and write-back controller for the STDP weight-update datapath. It drives the datapath's pre-spike timestamp, post-spike timestamp and previous-weight inputs, and accepts its new-weight output.
- Keeps a free-running Q16.16 time base and records the last pre- and post-synaptic spike times.
- Forms in-window spike pairs and issues one update per pair.
- Captures the returned weight into the synapse weight register.

Parameters:
- BUFFER_TIME, 32, timestamp width (Q16.16).
- BUFFER_SIZE, 32, weight width; the weight word is opaque to this block.
- TICK_INC, 32'h0001_0000, time increment per tick (1.0).
- WINDOW_T, 32'h0028_0000, pairing window (40.0); a pair is valid only when |delta| < WINDOW_T.
- W_INIT, 32'h0000_0000, weight value at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- tick_en  in  1  advance time base this cycle.
- pre_spike  in  1  pre-synaptic spike, sampled every clk.
- post_spike  in  1  post-synaptic spike, sampled every clk.
- w_load  in  1  host weight write, honoured only in IDLE.
- w_load_data  in  BUFFER_SIZE  host weight value.
- t_pre  out  BUFFER_TIME  to datapath; 0 when not issuing.
- t_post  out  BUFFER_TIME  to datapath; 0 when not issuing.
- w_previous  out  BUFFER_SIZE  to datapath; always equals weight.
- w_new  in  BUFFER_SIZE  from datapath; valid in the cycle after the timestamps are sampled.
- weight  out  BUFFER_SIZE  current synapse weight.
- busy  out  1  state != IDLE.
- update_done  out  1  one-cycle pulse after weight capture.

Behaviour:
- Reset (reset=0, async) sets:
  - now_t=TICK_INC; last_pre=last_post=0; pending flags=0.
  - t_pre=t_post=0; weight=W_INIT; state=IDLE; update_done=0.
- A timestamp of 0 means "no spike". now_t is never 0.
- Time base:
  - On tick_en, now_t += TICK_INC.
  - If the sum overflows or equals 0, now_t=TICK_INC, and last_pre, last_post and the pending stamps are cleared in the same cycle.
- Capture, in any state:
  - A spike with its pending slot empty sets the slot flag and records stamp = now_t before this cycle's increment.
  - A spike with its pending slot full is dropped.
- IDLE evaluation, one pass per cycle; w_load is handled first (weight<=w_load_data), and pending slots are not evaluated in that cycle.
  - Only post pending: last_post<=P. If last_pre!=0 and P-last_pre<WINDOW_T, issue (t_pre=last_pre, t_post=P).
  - Only pre pending: last_pre<=Q. If last_post!=0 and Q-last_post<WINDOW_T, issue (t_pre=Q, t_post=last_post). This gives a negative delta, i.e. depression.
  - Both pending: both records update. Issue (t_pre=Q, t_post=P) if |P-Q|<WINDOW_T. Equal stamps give delta 0.
  - Slots consumed are cleared in the same cycle. No issue means stay in IDLE.
- Issue sequence:
  - IDLE->ISSUE: t_pre/t_post are registered on entry and held through CAPTURE. The datapath samples them at the ISSUE->CAPTURE edge.
  - CAPTURE: at its ending edge, weight<=w_new, t_pre=t_post=0, update_done=1 for the next cycle, state->IDLE.
  - Latency: spike edge k, IDLE evaluation edge k+1, ISSUE k+2, weight updated at edge k+3, update_done high in cycle k+3..k+4.
- w_load outside IDLE is ignored; the host checks busy first.
- Reset asserted mid-issue aborts the update; weight returns to W_INIT.

Optional Feature:
- STDP_DROP_CNT_EN defined:
  - Adds output drop_cnt [15:0], counting spikes dropped on a full slot. Saturates at 16'hFFFF; reset to 0.
  - A simultaneous pre and post drop counts 2.
- STDP_DROP_CNT_EN undefined: no drop_cnt port and no counter logic.

Decomposition:
- Package stdp_pkg holds:
  - the state enum (IDLE, ISSUE, CAPTURE);
  - default constants TICK_INC and WINDOW_T;
  - a signed-difference width helper.
- One sub-module, stdp_time_base: the now_t counter with wrap detection; outputs now_t and a wrap_pulse.

Test Plan:
- Reset, W_INIT=32'h0000_1234 -> weight=32'h0000_1234, t_pre=t_post=0, now_t=32'h0001_0000, busy=0.
- Pre at now_t=32'h0003_0000, post at 32'h0008_0000, stub w_new=w_previous+1 -> exactly one issue with t_pre=32'h0003_0000, t_post=32'h0008_0000; weight +1 three edges after the post spike; update_done one cycle.
- Post at 32'h0005_0000, pre at 32'h0007_0000 -> issue with t_pre=32'h0007_0000, t_post=32'h0005_0000.
- Pre at 32'h0002_0000, post at 32'h002A_0000 (delta=40.0) -> no issue, weight unchanged; post at 32'h0029_0000 instead -> issue.
- Pre and post in the same cycle, with the other side holding no valid stamp -> one issue with t_pre=t_post=stamp. Third pre while a pre is pending during ISSUE -> dropped, drop_cnt=1 with STDP_DROP_CNT_EN.
- Force now_t=32'hFFFF_0000 with tick_en -> now_t=32'h0001_0000, last stamps cleared. Reset low during CAPTURE -> weight=W_INIT, state IDLE.
